// File: rtl/hack_boot_pkg.sv
// Shared types and constants for the Hack boot loader: FSM states, default
// geometry and the byte order of the big-endian length header.
package hack_boot_pkg;

  localparam int          ADDR_W_DEF = 15;
  localparam int          WORD_W_DEF = 16;
  localparam int unsigned DEPTH_DEF  = 32768;

  // Word count field carried by the two header bytes.
  localparam int LEN_W       = 16;
  localparam int LEN_HI_LANE = 1;  // first header byte lands in bits [15:8]
  localparam int LEN_LO_LANE = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CSUM,
    S_RUN,
    S_ERROR
  } boot_state_e;

  function automatic logic [LEN_W-1:0] make_len(input logic [7:0] hi, input logic [7:0] lo);
    logic [LEN_W-1:0] len;
    len = '0;
    len[LEN_HI_LANE*8 +: 8] = hi;
    len[LEN_LO_LANE*8 +: 8] = lo;
    return len;
  endfunction

endpackage

// File: rtl/hack_word_assembler.sv
// Collects the high/low bytes of each program word and keeps the running
// XOR of every data byte for the trailing checksum.
module hack_word_assembler
  import hack_boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_hi_we,
  input  logic        i_lo_we,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_word,
  output logic [7:0]  o_csum
);

  logic [7:0] r_hi;
  logic [7:0] r_lo;
  logic [7:0] r_csum;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_csum <= '0;
    end else if (i_clear) begin
      r_csum <= '0;
    end else if (i_hi_we) begin
      r_hi   <= i_byte;
      r_csum <= r_csum ^ i_byte;
    end else if (i_lo_we) begin
      r_lo   <= i_byte;
      r_csum <= r_csum ^ i_byte;
    end
  end

  assign o_word = {r_hi, r_lo};
  assign o_csum = r_csum;

endmodule

// File: rtl/hack_boot_sequencer.sv
// Loads a length-prefixed, XOR-checksummed program image from a byte stream
// into instruction memory, holding the CPU in reset until the image is good.
module hack_boot_sequencer
  import hack_boot_pkg::*;
#(
  parameter int          ADDR_W = ADDR_W_DEF,
  parameter int          WORD_W = WORD_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [WORD_W-1:0] rom_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  boot_state_e      r_state;
  boot_state_e      w_state_nxt;
  logic [7:0]       r_len_hi;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] w_len;
  logic [15:0]      w_word;
  logic [7:0]       w_csum;
  logic             w_accept;
  logic             w_start_load;

  assign w_accept     = rx_valid & rx_ready;
  assign w_len        = make_len(r_len_hi, rx_data);
  assign w_start_load = start && (r_state inside {S_IDLE, S_RUN, S_ERROR});

  hack_word_assembler u_asm (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_start_load),
    .i_hi_we (w_accept && (r_state == S_DATA_HI)),
    .i_lo_we (w_accept && (r_state == S_DATA_LO)),
    .i_byte  (rx_data),
    .o_word  (w_word),
    .o_csum  (w_csum)
  );

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_RUN, S_ERROR: if (start) w_state_nxt = S_LEN_HI;
      S_LEN_HI:  if (w_accept) w_state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (w_accept) begin
          if (w_len == '0)             w_state_nxt = S_CSUM;
          else if (32'(w_len) > DEPTH) w_state_nxt = S_ERROR;
          else                         w_state_nxt = S_DATA_HI;
        end
      end
      S_DATA_HI: if (w_accept) w_state_nxt = S_DATA_LO;
      S_DATA_LO: if (w_accept) w_state_nxt = S_WRITE;
      S_WRITE:   w_state_nxt = (r_count + LEN_W'(1) == r_len) ? S_CSUM : S_DATA_HI;
      S_CSUM: begin
        if (w_accept) w_state_nxt = (rx_data == w_csum) ? S_RUN : S_ERROR;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with r_state
  // while still coming straight out of flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_len_hi  <= '0;
      r_len     <= '0;
      r_count   <= '0;
      rom_we    <= 1'b0;
      rx_ready  <= 1'b0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_load)            r_count <= '0;
      else if (r_state == S_WRITE) r_count <= r_count + LEN_W'(1);
      if (w_accept && (r_state == S_LEN_HI)) r_len_hi <= rx_data;
      if (w_accept && (r_state == S_LEN_LO)) r_len    <= w_len;
      rom_we    <= (w_state_nxt == S_WRITE);
      rx_ready  <= (w_state_nxt inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM});
      busy      <= !(w_state_nxt inside {S_IDLE, S_RUN, S_ERROR});
      done      <= (w_state_nxt == S_RUN);
      err       <= (w_state_nxt == S_ERROR);
      cpu_reset <= (w_state_nxt != S_RUN);
    end
  end

  assign rom_addr  = ADDR_W'(r_count);
  assign rom_wdata = WORD_W'(w_word);

endmodule

// File: tb/tb_hack_boot_sequencer.sv
// Directed bench for hack_boot_sequencer: good/bad checksum loads, empty and
// oversize images, stalled handshakes, and reset in the middle of a load.
module tb_hack_boot_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        rom_we;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t0     = 0;

  logic [31:0] wlog[$];
  logic [7:0]  bytes_q[$];

  // Flag vector order: {rom_we, rx_ready, cpu_reset, busy, done, err}
  localparam logic [5:0] F_IDLE  = 6'b001000;
  localparam logic [5:0] F_RUN   = 6'b000010;
  localparam logic [5:0] F_ERROR = 6'b001001;

  hack_boot_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rom_we === 1'b1) wlog.push_back({1'b0, rom_addr, rom_wdata});
  end

  function automatic logic [5:0] flags();
    return {rom_we, rx_ready, cpu_reset, busy, done, err};
  endfunction

  function automatic logic [31:0] wr(input int i);
    return (wlog.size() > i) ? wlog[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte and return at the negedge after it was handshaked.
  task automatic send_byte(input logic [7:0] b, input bit gappy);
    int n;
    if (gappy) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (rx_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    if (rx_ready !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $error("FAIL hs_timeout: observed rx_ready %b expected 1", rx_ready);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input bit gappy, input bit poke_start);
    wlog.delete();
    @(negedge clk);
    start = 1'b1;
    t0    = cyc + 1;
    foreach (bytes_q[i]) begin
      if (poke_start && i == 4) start = 1'b1;
      send_byte(bytes_q[i], gappy);
    end
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_flags", 32'(flags()), 32'(F_IDLE));
    check("rst_addr",  32'(rom_addr), 32'd0);
    check("rst_wdata", 32'(rom_wdata), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_flags", 32'(flags()), 32'(F_IDLE));

    // Two words; checksum 12^34^AB^CD = 40.
    bytes_q = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_load(1'b0, 1'b0);
    check("a_flags",  32'(flags()), 32'(F_RUN));
    check("a_nwr",    32'(wlog.size()), 32'd2);
    check("a_w0",     wr(0), 32'h0000_1234);
    check("a_w1",     wr(1), 32'h0001_ABCD);
    check("a_cycles", 32'(cyc - t0), 32'd9);

    bytes_q = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    run_load(1'b0, 1'b0);
    check("b_flags", 32'(flags()), 32'(F_ERROR));
    check("b_nwr",   32'(wlog.size()), 32'd2);
    check("b_w0",    wr(0), 32'h0000_1234);
    check("b_w1",    wr(1), 32'h0001_ABCD);

    bytes_q = {8'h00, 8'h00, 8'h00};
    run_load(1'b0, 1'b0);
    check("c_flags",  32'(flags()), 32'(F_RUN));
    check("c_nwr",    32'(wlog.size()), 32'd0);
    check("c_cycles", 32'(cyc - t0), 32'd3);

    // 0x8001 words exceeds the 32768-word image limit.
    bytes_q = {8'h80, 8'h01};
    run_load(1'b0, 1'b0);
    check("d_flags", 32'(flags()), 32'(F_ERROR));
    check("d_nwr",   32'(wlog.size()), 32'd0);

    bytes_q = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_load(1'b1, 1'b1);
    check("e_flags", 32'(flags()), 32'(F_RUN));
    check("e_nwr",   32'(wlog.size()), 32'd2);
    check("e_w0",    wr(0), 32'h0000_1234);
    check("e_w1",    wr(1), 32'h0001_ABCD);

    // Reset arriving during the first write of a four-word load.
    wlog.delete();
    @(negedge clk);
    start = 1'b1;
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rx_valid = 1'b0;
    check("f_first_we", 32'(rom_we), 32'd1);
    #1 reset = 1'b0;
    #1 check("f_abort_flags", 32'(flags()), 32'(F_IDLE));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("f_nwr",     32'(wlog.size()), 32'd1);
    check("f_w0",      wr(0), 32'h0000_1122);
    check("f_idle",    32'(flags()), 32'(F_IDLE));

    bytes_q = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_load(1'b0, 1'b0);
    check("g_flags", 32'(flags()), 32'(F_RUN));
    check("g_nwr",   32'(wlog.size()), 32'd2);
    check("g_w0",    wr(0), 32'h0000_1234);
    check("g_w1",    wr(1), 32'h0001_ABCD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
